// File: rtl/conv_buf_pkg.sv
// Shared types and helpers for the convolution filter weight buffer.
package conv_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    localparam int DATA_W_DEF = 8;
    localparam int K_DEF      = 4;
    localparam int DEPTH_DEF  = 4;
    localparam int ROW_W      = K_DEF * DATA_W_DEF;
    localparam int FILT_W     = K_DEF * K_DEF * DEPTH_DEF * DATA_W_DEF;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_filter_buf_if.sv
// Row-load stream plus filter read port of the convolution filter buffer.
interface conv_filter_buf_if #(
  parameter int DATA_W = 8,
  parameter int K      = 4,
  parameter int DEPTH  = 4
);
  import conv_buf_pkg::*;

  localparam int RIW = idx_w(K);
  localparam int DIW = idx_w(DEPTH);

  logic                          in_valid;
  logic                          in_ready;
  logic [K*DATA_W-1:0]           in_data;
  logic                          out_valid;
  logic [K*K*DEPTH*DATA_W-1:0]   out_data;
  logic                          out_release;
  logic [RIW-1:0]                row_idx;
  logic [DIW-1:0]                depth_idx;

  modport master (
    output in_valid, in_data, out_release,
    input  in_ready, out_valid, out_data, row_idx, depth_idx
  );

  modport slave (
    input  in_valid, in_data, out_release,
    output in_ready, out_valid, out_data, row_idx, depth_idx
  );

endinterface

// File: rtl/conv_filter_buf_bank.sv
// filter_bank: one KxKxDEPTH weight store, row write port, flattened MSB-first read.
module filter_bank
  import conv_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = K_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [idx_w(K)-1:0]                 row,
  input  logic [idx_w(DEPTH)-1:0]             depth,
  input  logic [K*DATA_W-1:0]                 data,
  output logic [K*K*DEPTH*DATA_W-1:0]         rd_data
);
  localparam int ROW_BITS  = K * DATA_W;
  localparam int FILT_BITS = K * K * DEPTH * DATA_W;

  logic [ROW_BITS-1:0] mem_r [DEPTH][K];

  // Weights are deliberately left unreset; they are only visible once a bank is FULL.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[depth][row] <= data;
    end
  end

  // Channel 0 row 0 lands in the top bits, rows then channels follow downward.
  always_comb begin
    rd_data = {FILT_BITS{1'b0}};
    for (int d = 0; d < DEPTH; d++) begin
      for (int r = 0; r < K; r++) begin
        rd_data[FILT_BITS-1-(d*K+r)*ROW_BITS -: ROW_BITS] = mem_r[d][r];
      end
    end
  end

endmodule

// File: rtl/conv_filter_buf.sv
// Convolution filter weight buffer: row/depth sequenced loads, optional
// second bank enabled by FILTER_BUF_PINGPONG_EN.
module conv_filter_buf
  import conv_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = K_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  conv_filter_buf_if.slave  bus
);
  localparam int FILT_BITS = K * K * DEPTH * DATA_W;
  localparam int RIW       = idx_w(K);
  localparam int DIW       = idx_w(DEPTH);
  localparam logic [RIW-1:0] ROW_LAST   = RIW'(K - 1);
  localparam logic [DIW-1:0] DEPTH_LAST = DIW'(DEPTH - 1);

  bank_state_t          bank_st_r [2];
  logic                 wr_ptr_r;
  logic                 rd_ptr_r;
  logic [RIW-1:0]       row_r;
  logic [DIW-1:0]       depth_r;
  logic [FILT_BITS-1:0] bank_data_s [2];
  logic                 ready_s;
  logic                 valid_s;
  logic                 accept_s;
  logic                 last_s;
  logic                 release_s;

  // Handshake decodes come only from registered state.
  always_comb begin
    ready_s   = (bank_st_r[wr_ptr_r] != FULL);
    valid_s   = (bank_st_r[rd_ptr_r] == FULL);
    accept_s  = bus.in_valid && ready_s && rst_n && !flush;
    last_s    = accept_s && (row_r == ROW_LAST) && (depth_r == DEPTH_LAST);
    release_s = bus.out_release && valid_s && rst_n && !flush;
  end

  filter_bank #(.DATA_W(DATA_W), .K(K), .DEPTH(DEPTH)) u_bank0 (
    .clk     (clk),
    .we      (accept_s && !wr_ptr_r),
    .row     (row_r),
    .depth   (depth_r),
    .data    (bus.in_data),
    .rd_data (bank_data_s[0])
  );

`ifdef FILTER_BUF_PINGPONG_EN
  filter_bank #(.DATA_W(DATA_W), .K(K), .DEPTH(DEPTH)) u_bank1 (
    .clk     (clk),
    .we      (accept_s && wr_ptr_r),
    .row     (row_r),
    .depth   (depth_r),
    .data    (bus.in_data),
    .rd_data (bank_data_s[1])
  );
`else
  assign bank_data_s[1] = {FILT_BITS{1'b0}};
`endif

  // Sequencing counters, bank states and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      bank_st_r[0] <= EMPTY;
      bank_st_r[1] <= EMPTY;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      row_r        <= {RIW{1'b0}};
      depth_r      <= {DIW{1'b0}};
    end else begin
      if (accept_s) begin
        if (row_r == ROW_LAST) begin
          row_r   <= {RIW{1'b0}};
          depth_r <= (depth_r == DEPTH_LAST) ? {DIW{1'b0}} : depth_r + DIW'(1);
        end else begin
          row_r   <= row_r + RIW'(1);
        end
        bank_st_r[wr_ptr_r] <= last_s ? FULL : LOADING;
`ifdef FILTER_BUF_PINGPONG_EN
        if (last_s) begin
          wr_ptr_r <= ~wr_ptr_r;
        end
`endif
      end
      // With two banks the load and release always target different banks.
      if (release_s) begin
        bank_st_r[rd_ptr_r] <= EMPTY;
`ifdef FILTER_BUF_PINGPONG_EN
        rd_ptr_r <= ~rd_ptr_r;
`endif
      end
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = valid_s;
  assign bus.out_data  = valid_s ? bank_data_s[rd_ptr_r] : {FILT_BITS{1'b0}};
  assign bus.row_idx   = row_r;
  assign bus.depth_idx = depth_r;

endmodule

// File: tb/tb_conv_filter_buf.sv
// Self-checking bench for conv_filter_buf (default and K=3/DEPTH=5 instances).
module tb_conv_filter_buf;
  localparam int DW  = 8;
  localparam int K   = 4;
  localparam int D   = 4;
  localparam int RW  = K * DW;
  localparam int FW  = K * K * D * DW;
  localparam int K3  = 3;
  localparam int D3  = 5;
  localparam int RW3 = K3 * DW;
  localparam int FW3 = K3 * K3 * D3 * DW;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  conv_filter_buf_if #(.DATA_W(DW), .K(K),  .DEPTH(D))  bus  ();
  conv_filter_buf_if #(.DATA_W(DW), .K(K3), .DEPTH(D3)) bus3 ();

  conv_filter_buf #(.DATA_W(DW), .K(K), .DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );
  conv_filter_buf #(.DATA_W(DW), .K(K3), .DEPTH(D3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus3)
  );

  typedef struct {
    logic [7:0]  base;
    logic        stall;
    logic [31:0] exp_top;
    logic [31:0] exp_bot;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  logic [FW-1:0]  sb_q [$];
  logic [FW-1:0]  model;
  logic [FW-1:0]  filt_a;
  logic [FW3-1:0] model3;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Stream one full filter; beat b carries byte (base+b) in every column.
  task automatic load(input logic [7:0] base, input logic stall);
    logic [7:0] v;
    for (int b = 0; b < K * D; b++) begin
      if (stall) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("row_idx",   FW'(bus.row_idx),   FW'(b % K));
      chk("depth_idx", FW'(bus.depth_idx), FW'(b / K));
      chk("in_ready_load", FW'(bus.in_ready), FW'(1'b1));
      v = base + 8'(b);
      bus.in_valid = 1'b1;
      bus.in_data  = {4{v}};
      model[FW-1-b*RW -: RW] = {4{v}};
      if (b == K * D - 1) sb_q.push_back(model);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic present_check();
    chk("out_valid_present", FW'(bus.out_valid), FW'(1'b1));
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      chk("out_data", bus.out_data, sb_q.pop_front());
    end
  endtask

  task automatic release_check();
    bus.out_release = 1'b1;
    @(negedge clk);
    bus.out_release = 1'b0;
    chk("out_valid_rel", FW'(bus.out_valid), FW'(1'b0));
    chk("out_data_rel",  bus.out_data, {FW{1'b0}});
    chk("in_ready_rel",  FW'(bus.in_ready), FW'(1'b1));
  endtask

  initial begin
    vecs[0] = '{8'h00, 1'b0, 32'h00000000, 32'h0F0F0F0F};
    vecs[1] = '{8'h00, 1'b1, 32'h00000000, 32'h0F0F0F0F};
    vecs[2] = '{8'h10, 1'b1, 32'h10101010, 32'h1F1F1F1F};
    vecs[3] = '{8'hF8, 1'b0, 32'hF8F8F8F8, 32'h07070707};

    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_release = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_release = 1'b0;
    model = '0; model3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  FW'(bus.in_ready),  FW'(1'b1));
    chk("rst_out_valid", FW'(bus.out_valid), FW'(1'b0));
    chk("rst_out_data",  bus.out_data, {FW{1'b0}});
    chk("rst_row_idx",   FW'(bus.row_idx),   FW'(0));
    chk("rst_depth_idx", FW'(bus.depth_idx), FW'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      load(vecs[i].base, vecs[i].stall);
      present_check();
      chk("out_top_word", FW'(bus.out_data[FW-1 -: 32]), FW'(vecs[i].exp_top));
      chk("out_bot_word", FW'(bus.out_data[31:0]),       FW'(vecs[i].exp_bot));
`ifdef FILTER_BUF_PINGPONG_EN
      chk("in_ready_full", FW'(bus.in_ready), FW'(1'b1));
`else
      chk("in_ready_full", FW'(bus.in_ready), FW'(1'b0));
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hDEADBEEF;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("beat_while_full_row", FW'(bus.row_idx), FW'(0));
      chk("beat_while_full_data", bus.out_data, model);
`endif
      release_check();
      bus.out_release = 1'b1;
      @(negedge clk);
      bus.out_release = 1'b0;
      chk("spurious_rel_valid", FW'(bus.out_valid), FW'(1'b0));
      chk("spurious_rel_ready", FW'(bus.in_ready),  FW'(1'b1));
      chk("spurious_rel_row",   FW'(bus.row_idx),   FW'(0));
    end

    // Overlap: second filter preloads behind the presented one when two banks exist.
    load(8'h20, 1'b0);
    filt_a = sb_q[0];
    present_check();
`ifdef FILTER_BUF_PINGPONG_EN
    load(8'h30, 1'b0);
    chk("pp_in_ready_both_full", FW'(bus.in_ready), FW'(1'b1) ^ FW'(1'b1));
    chk("pp_still_a", bus.out_data, filt_a);
    bus.out_release = 1'b1;
    @(negedge clk);
    bus.out_release = 1'b0;
    present_check();
    chk("pp_in_ready_after_rel", FW'(bus.in_ready), FW'(1'b1));
    release_check();
`else
    chk("sb_in_ready_a_full", FW'(bus.in_ready), FW'(1'b0));
    release_check();
`endif

    // Flush after 7 beats, the flush cycle also carrying a beat.
    for (int b = 0; b < 7; b++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = {4{8'hA0 + 8'(b)}};
    end
    @(negedge clk);
    flush = 1'b1;
    bus.in_data = 32'h77777777;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_row_idx",   FW'(bus.row_idx),   FW'(0));
    chk("flush_depth_idx", FW'(bus.depth_idx), FW'(0));
    chk("flush_out_valid", FW'(bus.out_valid), FW'(1'b0));
    chk("flush_in_ready",  FW'(bus.in_ready),  FW'(1'b1));
    load(8'h40, 1'b0);
    present_check();
    release_check();

    // K=3, DEPTH=5 instance: 15-beat load, row wraps after 2.
    for (int b = 0; b < K3 * D3; b++) begin
      logic [7:0] v;
      @(negedge clk);
      chk("k3_row_idx",   FW'(bus3.row_idx),   FW'(b % K3));
      chk("k3_depth_idx", FW'(bus3.depth_idx), FW'(b / K3));
      v = 8'h60 + 8'(b);
      bus3.in_valid = 1'b1;
      bus3.in_data  = {3{v}};
      model3[FW3-1-b*RW3 -: RW3] = {3{v}};
    end
    @(negedge clk);
    bus3.in_valid = 1'b0;
    chk("k3_out_valid", FW'(bus3.out_valid), FW'(1'b1));
    chk("k3_out_data",  FW'(bus3.out_data),  FW'(model3));
    chk("k3_row_after", FW'(bus3.row_idx),   FW'(0));
    bus3.out_release = 1'b1;
    @(negedge clk);
    bus3.out_release = 1'b0;
    chk("k3_rel_valid", FW'(bus3.out_valid), FW'(1'b0));

    // Reset while a filter is presented clears it.
    load(8'h55, 1'b0);
    present_check();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_full_valid", FW'(bus.out_valid), FW'(1'b0));
    chk("rst_full_data",  bus.out_data, {FW{1'b0}});
    chk("rst_full_ready", FW'(bus.in_ready), FW'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
